traffic_light_ctrl: RTL and testbench

- Four-phase, two-direction traffic light controller: north-south (NS) and east-west (EW).
- Owns the 1 Hz time base, the phase FSM and the per-direction remaining-seconds counters.
- Sits directly upstream of the two-digit 7-segment decode stage: ns_num and ew_num each feed one decode instance as a 6-bit value (0..63). The light vectors drive the lamp pins.

---
 rtl/traffic_light_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - four-phase NS/EW traffic light controller with 1 Hz time base (optional TLC_NIGHT_MODE_EN)
module traffic_light_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int NS_GREEN_T  = 30,
    parameter int NS_YELLOW_T = 3,
    parameter int EW_GREEN_T  = 25,
    parameter int EW_YELLOW_T = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       night,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [5:0] ns_num,
    output logic [5:0] ew_num,
    output logic       tick
);

    localparam logic [25:0] PRE_LAST = 26'(TICK_DIV - 1);
    localparam logic [5:0]  NSG_T    = 6'(NS_GREEN_T);
    localparam logic [5:0]  NSY_T    = 6'(NS_YELLOW_T);
    localparam logic [5:0]  EWG_T    = 6'(EW_GREEN_T);
    localparam logic [5:0]  EWY_T    = 6'(EW_YELLOW_T);

    // Combined green+yellow must fit the 6-bit display path without wrapping.
    generate
        if (NS_GREEN_T + NS_YELLOW_T > 63) begin : g_ns_range_err
            $error("NS_GREEN_T + NS_YELLOW_T exceeds 63");
        end
        if (EW_GREEN_T + EW_YELLOW_T > 63) begin : g_ew_range_err
            $error("EW_GREEN_T + EW_YELLOW_T exceeds 63");
        end
        if (TICK_DIV < 2 || TICK_DIV > (1 << 26)) begin : g_div_range_err
            $error("TICK_DIV out of range 2..2^26");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_NSG   = 3'd0,
        S_NSY   = 3'd1,
        S_EWG   = 3'd2,
`ifdef TLC_NIGHT_MODE_EN
        S_EWY   = 3'd3,
        S_NIGHT = 3'd4
`else
        S_EWY   = 3'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [25:0] pre_q, pre_d;
    state_t      adv_state;
    logic [5:0]  adv_dur;
    logic        legal;

`ifdef TLC_NIGHT_MODE_EN
    logic blink_q, blink_d;
`else
    logic unused_night;
    assign unused_night = night;
`endif

    // State, phase counter and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NSG;
            cnt_q   <= NSG_T;
            pre_q   <= '0;
`ifdef TLC_NIGHT_MODE_EN
            blink_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
`ifdef TLC_NIGHT_MODE_EN
            blink_q <= blink_d;
`endif
        end
    end

    // Prescaler, tick generation and phase sequencing.
    always_comb begin
        pre_d     = pre_q;
        tick      = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        adv_state = S_NSG;
        adv_dur   = NSG_T;
        legal     = 1'b1;
`ifdef TLC_NIGHT_MODE_EN
        blink_d   = blink_q;
`endif

        // hold freezes the prescaler in place, so a pending tick is deferred, not dropped
        if (!hold) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 26'd1;
            end
        end

        case (state_q)
            S_NSG:   begin adv_state = S_NSY; adv_dur = NSY_T; end
            S_NSY:   begin adv_state = S_EWG; adv_dur = EWG_T; end
            S_EWG:   begin adv_state = S_EWY; adv_dur = EWY_T; end
            S_EWY:   begin adv_state = S_NSG; adv_dur = NSG_T; end
            default: legal = 1'b0;
        endcase

`ifdef TLC_NIGHT_MODE_EN
        if (state_q == S_NIGHT) begin
            if (!night) begin
                state_d = S_NSG;
                cnt_d   = NSG_T;
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end else if (night) begin
            state_d = S_NIGHT;
            blink_d = 1'b1;
        end else
`endif
        if (!legal) begin
            state_d = S_NSG;
            cnt_d   = NSG_T;
        end else if (tick) begin
            // cnt==1 is the last second of the phase: move on and load the next duration together
            if (cnt_q == 6'd1) begin
                state_d = adv_state;
                cnt_d   = adv_dur;
            end else begin
                cnt_d = cnt_q - 6'd1;
            end
        end
    end

    // Lamp and countdown outputs decoded from the current phase.
    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        ns_num   = '0;
        ew_num   = '0;
        case (state_q)
            S_NSG: begin
                ns_light = 3'b001;
                ns_num   = cnt_q;
                ew_num   = cnt_q + NSY_T;
            end
            S_NSY: begin
                ns_light = 3'b010;
                ns_num   = cnt_q;
                ew_num   = cnt_q;
            end
            S_EWG: begin
                ew_light = 3'b001;
                ew_num   = cnt_q;
                ns_num   = cnt_q + EWY_T;
            end
            S_EWY: begin
                ew_light = 3'b010;
                ew_num   = cnt_q;
                ns_num   = cnt_q;
            end
`ifdef TLC_NIGHT_MODE_EN
            S_NIGHT: begin
                ns_light = {1'b0, blink_q, 1'b0};
                ew_light = {1'b0, blink_q, 1'b0};
            end
`endif
            default: begin
                ns_light = 3'b100;
                ew_light = 3'b100;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic       night;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [5:0] ns_num;
    logic [5:0] ew_num;
    logic       tick;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    traffic_light_ctrl #(
        .TICK_DIV    (4),
        .NS_GREEN_T  (5),
        .NS_YELLOW_T (2),
        .EW_GREEN_T  (4),
        .EW_YELLOW_T (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .night    (night),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ns_num   (ns_num),
        .ew_num   (ew_num),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tick_no;
        logic [2:0] ns_l;
        logic [2:0] ew_l;
        logic [5:0] ns_n;
        logic [5:0] ew_n;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string name, input logic [2:0] nl, input logic [2:0] el,
                            input logic [5:0] nn, input logic [5:0] en);
        chk({name, ".ns_light"}, 32'(ns_light), 32'(nl));
        chk({name, ".ew_light"}, 32'(ew_light), 32'(el));
        chk({name, ".ns_num"},   32'(ns_num),   32'(nn));
        chk({name, ".ew_num"},   32'(ew_num),   32'(en));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Lamp safety: at least one direction red, each lamp vector one-hot.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_en) begin
            checks++;
            if (!(ns_light[2] | ew_light[2]) || !$onehot(ns_light) || !$onehot(ew_light)) begin
                failures++;
                $display("FAIL light_safety: ns=%b ew=%b at %0t", ns_light, ew_light, $time);
            end
        end
    end

    initial begin
        tbl[0]  = '{0,  3'b001, 3'b100, 6'd5, 6'd7};
        tbl[1]  = '{1,  3'b001, 3'b100, 6'd4, 6'd6};
        tbl[2]  = '{2,  3'b001, 3'b100, 6'd3, 6'd5};
        tbl[3]  = '{3,  3'b001, 3'b100, 6'd2, 6'd4};
        tbl[4]  = '{4,  3'b001, 3'b100, 6'd1, 6'd3};
        tbl[5]  = '{5,  3'b010, 3'b100, 6'd2, 6'd2};
        tbl[6]  = '{6,  3'b010, 3'b100, 6'd1, 6'd1};
        tbl[7]  = '{7,  3'b100, 3'b001, 6'd7, 6'd4};
        tbl[8]  = '{8,  3'b100, 3'b001, 6'd6, 6'd3};
        tbl[9]  = '{9,  3'b100, 3'b001, 6'd5, 6'd2};
        tbl[10] = '{10, 3'b100, 3'b001, 6'd4, 6'd1};
        tbl[11] = '{11, 3'b100, 3'b010, 6'd3, 6'd3};
        tbl[12] = '{12, 3'b100, 3'b010, 6'd2, 6'd2};
        tbl[13] = '{13, 3'b100, 3'b010, 6'd1, 6'd1};
        tbl[14] = '{14, 3'b001, 3'b100, 6'd5, 6'd7};

        rst_n = 1'b0;
        hold  = 1'b0;
        night = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 3'b001, 3'b100, 6'd5, 6'd7);
        chk("reset.tick", 32'(tick), 32'd0);

        rst_n  = 1'b1;
        mon_en = 1'b1;

        // One full light cycle, checked right after every tick edge.
        for (int t = 0; t < 15; t++) begin
            chk_outs($sformatf("tick%0d", tbl[t].tick_no), tbl[t].ns_l, tbl[t].ew_l,
                     tbl[t].ns_n, tbl[t].ew_n);
            chk($sformatf("tick%0d.tick_low", tbl[t].tick_no), 32'(tick), 32'd0);
            if (t < 14) begin
                step(3);
                chk($sformatf("tick%0d.tick_pulse", tbl[t].tick_no + 1), 32'(tick), 32'd1);
                step(1);
            end
        end

        // Hold mid-interval at ns_num=3 with prescaler at 1.
        step(8);
        chk_outs("pre_hold", 3'b001, 3'b100, 6'd3, 6'd5);
        step(1);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold.tick", 32'(tick), 32'd0);
            chk("hold.ns_num", 32'(ns_num), 32'd3);
        end
        hold = 1'b0;
        step(2);
        chk("hold_release.tick", 32'(tick), 32'd1);
        chk("hold_release.ns_num", 32'(ns_num), 32'd3);
        step(1);
        chk_outs("after_hold", 3'b001, 3'b100, 6'd2, 6'd4);

        // Hold asserted on the very cycle a tick is due.
        step(3);
        chk("tick_due", 32'(tick), 32'd1);
        hold = 1'b1;
        #1;
        chk("hold_suppress.tick", 32'(tick), 32'd0);
        step(2);
        chk("hold_suppress.ns_num", 32'(ns_num), 32'd2);
        chk("hold_suppress.tick2", 32'(tick), 32'd0);
        hold = 1'b0;
        #1;
        chk("hold_resume.tick", 32'(tick), 32'd1);
        step(1);
        chk_outs("after_suppress", 3'b001, 3'b100, 6'd1, 6'd3);

        // Into S_EWY, then async reset between clock edges.
        step(28);
        chk_outs("ewy", 3'b100, 3'b010, 6'd3, 6'd3);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_reset", 3'b001, 3'b100, 6'd5, 6'd7);
        chk("async_reset.tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        chk("post_reset.tick", 32'(tick), 32'd1);
        chk("post_reset.ns_num", 32'(ns_num), 32'd5);
        step(1);
        chk_outs("post_reset_tick1", 3'b001, 3'b100, 6'd4, 6'd6);

        // Reach S_EWG for the night request.
        step(24);
        chk_outs("ewg", 3'b100, 3'b001, 6'd7, 6'd4);
`ifdef TLC_NIGHT_MODE_EN
        mon_en = 1'b0;
        night  = 1'b1;
        step(1);
        chk_outs("night_entry", 3'b010, 3'b010, 6'd0, 6'd0);
        step(2);
        chk("night.tick", 32'(tick), 32'd1);
        step(1);
        chk_outs("night_blink0", 3'b000, 3'b000, 6'd0, 6'd0);
        step(4);
        chk_outs("night_blink1", 3'b010, 3'b010, 6'd0, 6'd0);
        night = 1'b0;
        step(1);
        chk_outs("night_exit", 3'b001, 3'b100, 6'd5, 6'd7);
        mon_en = 1'b1;
`else
        night = 1'b1;
        step(2);
        chk_outs("night_ignored", 3'b100, 3'b001, 6'd7, 6'd4);
        step(2);
        chk_outs("night_ignored_tick", 3'b100, 3'b001, 6'd6, 6'd3);
        night = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
